// File: rtl/vault_flash_ctrl.sv
// vault_flash_ctrl: lookup/store controller scanning the 16-entry vault memory.
// Define VAULT_ERASE_EN to enable cmd_op 2 (erase); otherwise it is rejected as illegal.
module vault_flash_ctrl (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [127:0] cmd_account,
  input  logic [127:0] cmd_pw_enc,
  input  logic [3:0]   max_address,
  output logic [3:0]   mem_addr,
  output logic         mem_we,
  output logic [255:0] mem_wdata,
  input  logic [255:0] mem_rdata,
  output logic         rsp_valid,
  output logic [1:0]   rsp_status,
  output logic [127:0] rsp_pw_enc,
  output logic [3:0]   rsp_addr,
  output logic         busy
);
  typedef enum logic [2:0] {IDLE, RD, CMP, WR, RSP} state_t;
  state_t state_q, state_d;
  logic [1:0] op_q, op_d, st_q, st_d;
  logic [127:0] acc_q, acc_d, pw_q, pw_d, rpw_q, rpw_d;
  logic [3:0] max_q, max_d, ptr_q, ptr_d, slot_q, slot_d, addr_q, addr_d;
  logic ef_q, ef_d, we_q, we_d, legal_op, hit, empty, fill;
`ifdef VAULT_ERASE_EN
  assign legal_op = cmd_op != 2'd3;
`else
  assign legal_op = !cmd_op[1];
`endif
  assign hit = mem_rdata[255:128] == acc_q;
  assign empty = ~|mem_rdata[255:128];
  assign fill = ef_q || empty;
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    acc_d = acc_q;
    pw_d = pw_q;
    rpw_d = rpw_q;
    max_d = max_q;
    ptr_d = ptr_q;
    slot_d = slot_q;
    addr_d = addr_q;
    ef_d = ef_q;
    we_d = we_q;
    st_d = st_q;
    case (state_q)
      IDLE: if (cmd_valid) begin
        op_d = cmd_op;
        acc_d = cmd_account;
        pw_d = cmd_pw_enc;
        max_d = max_address;
        ptr_d = '0;
        ef_d = 1'b0;
        we_d = 1'b0;
        rpw_d = '0;
        if (legal_op && |cmd_account) begin
          state_d = RD;
          addr_d = '0;
        end else begin
          state_d = RSP;
          st_d = 2'd3;
        end
      end
      RD: state_d = CMP;
      CMP: if (hit) begin
        state_d = op_q == 2'd0 ? RSP : WR;
        we_d = op_q != 2'd0;
        st_d = 2'd0;
        rpw_d = op_q == 2'd0 ? mem_rdata[127:0] : '0;
      end else if (ptr_q == max_q) begin
        // a store that misses always spends the WR slot, writing only if a hole was seen
        state_d = op_q == 2'd1 ? WR : RSP;
        we_d = op_q == 2'd1 && fill;
        st_d = op_q != 2'd1 ? 2'd1 : fill ? 2'd0 : 2'd2;
        addr_d = ef_q ? slot_q : ptr_q;
      end else begin
        state_d = RD;
        ptr_d = ptr_q + 4'd1;
        addr_d = ptr_q + 4'd1;
        ef_d = fill;
        slot_d = ef_q ? slot_q : ptr_q;
      end
      WR: state_d = RSP;
      RSP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      op_q <= '0;
      acc_q <= '0;
      pw_q <= '0;
      rpw_q <= '0;
      max_q <= '0;
      ptr_q <= '0;
      slot_q <= '0;
      addr_q <= '0;
      ef_q <= 1'b0;
      we_q <= 1'b0;
      st_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      acc_q <= acc_d;
      pw_q <= pw_d;
      rpw_q <= rpw_d;
      max_q <= max_d;
      ptr_q <= ptr_d;
      slot_q <= slot_d;
      addr_q <= addr_d;
      ef_q <= ef_d;
      we_q <= we_d;
      st_q <= st_d;
    end
  assign cmd_ready = state_q == IDLE;
  assign busy = !cmd_ready;
  assign mem_addr = addr_q;
  assign mem_we = state_q == WR && we_q;
  assign mem_wdata = mem_we && op_q == 2'd1 ? {acc_q, pw_q} : '0;
  assign rsp_valid = state_q == RSP;
  assign rsp_status = rsp_valid ? st_q : 2'd0;
  assign rsp_pw_enc = rsp_valid ? rpw_q : '0;
  assign rsp_addr = rsp_valid && st_q == 2'd0 ? addr_q : 4'd0;
endmodule
